lsu_load_store: RTL and testbench

- Load/store unit between the execute stage and the data-memory bus.
- Accepts one load or store per request, converts it to a word-aligned memory transaction with byte enables, and waits for the memory handshake.
- For loads, sign- or zero-extends the returned data and presents it as the memory-result input (d1) of the 32-bit 4:1 writeback result multiplexer.
- Flags misaligned accesses, illegal funct3 encodings and bus timeouts instead of issuing them.

---
 rtl/rv32i_pkg.sv | 34 +++
 rtl/lsu_load_align.sv | 31 +++
 rtl/lsu_load_store.sv | 179 +++++++++++++++++
 tb/tb_lsu_load_store.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU state encoding,
// byte-enable patterns and request-checking helpers.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Access size lives in funct3[1:0]; only half and word carry alignment rules.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
    if (f3[1:0] == 2'b01) return off[0];
    if (f3[1:0] == 2'b10) return off != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = mem_rdata >> {offset, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    rdata    = '0;
    case (funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_W:    rdata = mem_rdata;
      F3_BU:   rdata = {24'd0, byte_sel};
      F3_HU:   rdata = {16'd0, half_sel};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_load_store.sv
// Load/store unit: checks a request, issues one word-aligned bus transaction
// with byte enables, waits for mem_ready (or times out) and reports via done.
module lsu_load_store
  import rv32i_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             misaligned,
  output logic             illegal,
  output logic             bus_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             mis_q, mis_d;
  logic             ill_q, ill_d;
  logic             berr_q, berr_d;
  logic             mem_we_q, mem_we_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [WIDTH-1:0] load_data;
  logic [3:0]       lane_be;
  logic [WIDTH-1:0] lane_wdata;

  lsu_load_align u_align (
    .mem_rdata (mem_rdata),
    .offset    (off_q),
    .funct3    (f3_q),
    .rdata     (load_data)
  );

  // Lane placement for the incoming request; loads drive no write data.
  always_comb begin
    lane_be    = BE_W;
    lane_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        lane_be    = BE_B << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_be    = BE_H << req_addr[1:0];
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_be    = BE_W;
        lane_wdata = req_wdata;
      end
    endcase
    if (!req_we) lane_wdata = '0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    mis_d       = mis_q;
    ill_d       = ill_q;
    berr_d      = berr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          mis_d   = 1'b0;
          ill_d   = 1'b0;
          berr_d  = 1'b0;
          cnt_d   = '0;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          // An illegal encoding masks any alignment complaint.
          if (!f3_legal(req_we, req_funct3)) begin
            ill_d   = 1'b1;
            state_d = ST_DONE;
          end else if (addr_misaligned(req_funct3, req_addr[1:0])) begin
            mis_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            mem_we_d    = req_we;
            mem_be_d    = lane_be;
            mem_addr_d  = {req_addr[WIDTH-1:2], 2'b00};
            mem_wdata_d = lane_wdata;
            state_d     = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          if (!mem_we_q) rdata_d = load_data;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          berr_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      rdata_q     <= '0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
      berr_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
      ill_q       <= ill_d;
      berr_q      <= berr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign mem_req    = (state_q == ST_WAIT);
  assign rdata      = rdata_q;
  assign misaligned = mis_q;
  assign illegal    = ill_q;
  assign bus_err    = berr_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_load_store.sv
// Directed bench for lsu_load_store: table of single operations plus
// hand-written timeout and mid-transaction reset sequences.
module tb_lsu_load_store;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, misaligned, illegal, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_load_store #(.WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .misaligned (misaligned),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [31:0] exp_rdata;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
    logic        exp_mis;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic err;
    err = v.exp_mis | v.exp_ill;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (!err) begin
      chk({v.name, "_mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({v.name, "_done_early"}, {31'd0, done}, 32'd0);
      chk({v.name, "_mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
      chk({v.name, "_mem_addr"}, mem_addr, v.exp_maddr);
      chk({v.name, "_mem_be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
      if (v.we) chk({v.name, "_mem_wdata"}, mem_wdata, v.exp_mwdata);
      mem_ready = 1'b1;
      mem_rdata = v.mrd;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
    end
    chk({v.name, "_done"}, {31'd0, done}, 32'd1);
    chk({v.name, "_mem_req_off"}, {31'd0, mem_req}, 32'd0);
    chk({v.name, "_rdata"}, rdata, v.exp_rdata);
    chk({v.name, "_flags"}, {29'd0, misaligned, illegal, bus_err},
        {29'd0, v.exp_mis, v.exp_ill, 1'b0});
    @(negedge clk);
    chk({v.name, "_idle"}, {30'd0, busy, done}, 32'd0);
    chk({v.name, "_rdata_hold"}, rdata, v.exp_rdata);
    $display("vec %s: done rdata=0x%08h mis=%0b ill=%0b", v.name, rdata, misaligned, illegal);
  endtask

  initial begin
    int n_req;
    bit seen_done;

    //            name      we    f3      addr          wdata         mem_rdata     exp_rdata     exp_maddr    be       exp_mwdata    mis   ill
    vecs[0]  = '{"lw",     1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h100, 4'b1111, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{"lb",     1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'hFFFF_FF80, 32'h100, 4'b1000, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{"lbu",    1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'h0000_0080, 32'h100, 4'b1000, 32'h0,        1'b0, 1'b0};
    vecs[3]  = '{"sh",     1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'hFFFF_FFFF, 32'h0,        32'h200, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0};
    vecs[4]  = '{"lw_mis", 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         32'h0,        32'h0,   4'b0000, 32'h0,        1'b1, 1'b0};
    vecs[5]  = '{"ld_ill", 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 1'b1};
    vecs[6]  = '{"lh",     1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 32'hFFFF_8001, 32'h100, 4'b1100, 32'h0,        1'b0, 1'b0};
    vecs[7]  = '{"lhu",    1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h8001_F234, 32'h0000_F234, 32'h100, 4'b0011, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{"sb",     1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5, 32'h0,         32'h0,        32'h200, 4'b0010, 32'hA5A5_A5A5, 1'b0, 1'b0};
    vecs[9]  = '{"sw",     1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,         32'h0,        32'h300, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[10] = '{"st_ill", 1'b1, 3'b101, 32'h0000_0303, 32'h0,        32'h0,         32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 1'b1};
    vecs[11] = '{"lh_mis", 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,         32'h0,        32'h0,   4'b0000, 32'h0,        1'b1, 1'b0};
    vecs[12] = '{"lb_pos", 1'b0, 3'b000, 32'h0000_0401, 32'h0,        32'h0000_7F00, 32'h0000_007F, 32'h400, 4'b0010, 32'h0,        1'b0, 1'b0};
    vecs[13] = '{"lw_hi",  1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0,        32'h0123_4567, 32'h0123_4567, 32'hFFFF_FFFC, 4'b1111, 32'h0,   1'b0, 1'b0};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    #1;
    chk("reset_ctrl", {28'd0, busy, done, mem_req, mem_we}, 32'd0);
    chk("reset_flags", {29'd0, misaligned, illegal, bus_err}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_bus", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Timeout: ready never arrives, expect four request cycles then bus_err.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
    @(negedge clk);
    req_valid = 1'b0;
    n_req = 0; seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (done) seen_done = 1'b1;
      else begin
        if (mem_req) n_req++;
        @(negedge clk);
      end
    end
    chk("to_seen_done", {31'd0, seen_done}, 32'd1);
    chk("to_req_cycles", n_req, 32'd4);
    chk("to_bus_err", {29'd0, misaligned, illegal, bus_err}, 32'd1);
    chk("to_rdata", rdata, 32'd0);
    $display("timeout: req_cycles=%0d bus_err=%0b", n_req, bus_err);
    @(negedge clk);

    // Ready on the last allowed cycle beats the timeout.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h504;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) @(negedge clk);
    chk("to_ready_req4", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("to_ready_done", {31'd0, done}, 32'd1);
    chk("to_ready_berr", {31'd0, bus_err}, 32'd0);
    chk("to_ready_rdata", rdata, 32'h1122_3344);
    $display("late ready: done=%0b bus_err=%0b rdata=0x%08h", done, bus_err, rdata);
    @(negedge clk);

    // Asynchronous reset while waiting on the bus.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_wait_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_ctrl", {29'd0, mem_req, busy, done}, 32'd0);
    chk("rst_async_bus", mem_addr, 32'd0);
    $display("reset in WAIT: mem_req=%0b busy=%0b", mem_req, busy);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
